// File: rtl/bp_update_scheduler_if.sv
// ============================================================================
//  Module      : bp_update_scheduler_if
//  Description : Bundle of the branch-resolution lanes, the BTB/predictor
//                update port and the pipeline-control status signals seen by
//                bp_update_scheduler.
//                master : pipeline / BTB side (drives lanes, wr_ready, flush)
//                slave  : scheduler side (drives res_ready, wr_*, count,
//                         overflow_err)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bp_update_scheduler_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 16
);
   // resolved-branch lanes (lane 0 is always older than lane 1)
   logic                       r0_valid;
   logic [AW-1:0]              r0_bia;
   logic [AW-1:0]              r0_bta;
   logic                       r0_taken;
   logic                       r1_valid;
   logic [AW-1:0]              r1_bia;
   logic [AW-1:0]              r1_bta;
   logic                       r1_taken;
   logic                       res_ready;

   // BTB / predictor update port
   logic                       wr_valid;
   logic [AW-1:0]              wr_bia;
   logic [AW-1:0]              wr_bta;
   logic                       wr_taken;
   logic                       wr_ready;

   // pipeline control
   logic                       flush;
   logic [$clog2(DEPTH):0]     count;
   logic                       overflow_err;

   modport master (
      output r0_valid, r0_bia, r0_bta, r0_taken,
      output r1_valid, r1_bia, r1_bta, r1_taken,
      input  res_ready,
      input  wr_valid, wr_bia, wr_bta, wr_taken,
      output wr_ready,
      output flush,
      input  count, overflow_err
   );

   modport slave (
      input  r0_valid, r0_bia, r0_bta, r0_taken,
      input  r1_valid, r1_bia, r1_bta, r1_taken,
      output res_ready,
      output wr_valid, wr_bia, wr_bta, wr_taken,
      input  wr_ready,
      input  flush,
      output count, overflow_err
   );
endinterface

`default_nettype wire

// File: rtl/bp_update_scheduler.sv
// ============================================================================
//  Module      : bp_update_scheduler
//  Description : Serialises up to two resolved branches per cycle onto the
//                single BTB/predictor write port through a DEPTH-entry
//                program-order FIFO with a valid/ready output handshake.
//  Ports       : clk    - single clock, rising edge
//                rst_n  - synchronous active-low reset
//                bus    - bp_update_scheduler_if.slave (lanes r0/r1,
//                         res_ready, wr_* update port, flush, count,
//                         overflow_err)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_update_scheduler #(
   parameter int DEPTH = 4,
   parameter int AW    = 16
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   bp_update_scheduler_if.slave   bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [AW-1:0] bia;
      logic [AW-1:0] bta;
      logic          taken;
   } entry_t;

   // storage is intentionally not reset; only the pointers/count define
   // which entries are meaningful
   entry_t          mem_q [DEPTH];

   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q, ovf_d;

   logic            res_ready_w;
   logic            wr_valid_w;
   logic            deq_w;
   logic            wr0_en_w;
   logic            wr1_en_w;
   logic [PW-1:0]   wr1_idx_w;
   logic [1:0]      n_enq_w;
   entry_t          head_entry_w;

   always_comb begin
      // space for a full dual enqueue, judged on the registered count only
      res_ready_w = (count_q <= CW'(DEPTH - 2));
      wr_valid_w  = (count_q != '0);
      deq_w       = wr_valid_w && bus.wr_ready;

      wr0_en_w    = 1'b0;
      wr1_en_w    = 1'b0;
      n_enq_w     = 2'd0;
      // r1 lands right behind r0 when both are valid, else at the tail
      wr1_idx_w   = tail_q + PW'(bus.r0_valid);

      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      ovf_d       = ovf_q;

      if (bus.flush) begin
         // lanes are discarded and cannot raise overflow; a same-cycle
         // handshake is still considered delivered by the consumer
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (res_ready_w) begin
            wr0_en_w = bus.r0_valid;
            wr1_en_w = bus.r1_valid;
            n_enq_w  = {1'b0, bus.r0_valid} + {1'b0, bus.r1_valid};
         end else if (bus.r0_valid || bus.r1_valid) begin
            // whole cycle is dropped, never a partial enqueue
            ovf_d = 1'b1;
         end
         head_d  = head_q + PW'(deq_w);
         tail_d  = tail_q + PW'(n_enq_w);
         count_d = count_q + CW'(n_enq_w) - CW'(deq_w);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && wr0_en_w) begin
         mem_q[tail_q] <= '{bia: bus.r0_bia, bta: bus.r0_bta, taken: bus.r0_taken};
      end
      if (rst_n && wr1_en_w) begin
         mem_q[wr1_idx_w] <= '{bia: bus.r1_bia, bta: bus.r1_bta, taken: bus.r1_taken};
      end
   end

   // outputs are forced to zero when empty so that stale storage never
   // leaks out after reset or flush
   assign head_entry_w     = mem_q[head_q];
   assign bus.res_ready    = res_ready_w;
   assign bus.wr_valid     = wr_valid_w;
   assign bus.wr_bia       = wr_valid_w ? head_entry_w.bia   : '0;
   assign bus.wr_bta       = wr_valid_w ? head_entry_w.bta   : '0;
   assign bus.wr_taken     = wr_valid_w ? head_entry_w.taken : 1'b0;
   assign bus.count        = count_q;
   assign bus.overflow_err = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
// ============================================================================
//  Module      : tb_bp_update_scheduler
//  Description : Directed self-checking bench for bp_update_scheduler
//                (DEPTH=4, AW=16).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_update_scheduler;

   localparam int DEPTH = 4;
   localparam int AW    = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   bp_update_scheduler_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

   bp_update_scheduler #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, then settle away from it
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_lanes;
      bus.r0_valid = 1'b0; bus.r0_bia = '0; bus.r0_bta = '0; bus.r0_taken = 1'b0;
      bus.r1_valid = 1'b0; bus.r1_bia = '0; bus.r1_bta = '0; bus.r1_taken = 1'b0;
   endtask

   task automatic drive_r0(input logic [AW-1:0] bia, input logic [AW-1:0] bta, input logic tk);
      bus.r0_valid = 1'b1; bus.r0_bia = bia; bus.r0_bta = bta; bus.r0_taken = tk;
   endtask

   task automatic drive_r1(input logic [AW-1:0] bia, input logic [AW-1:0] bta, input logic tk);
      bus.r1_valid = 1'b1; bus.r1_bia = bia; bus.r1_bta = bta; bus.r1_taken = tk;
   endtask

   task automatic do_reset;
      clear_lanes();
      bus.flush    = 1'b0;
      bus.wr_ready = 1'b0;
      rst_n        = 1'b0;
      step();
      rst_n        = 1'b1;
   endtask

   task automatic test_reset;
      rst_n        = 1'b0;
      bus.flush    = 1'b0;
      bus.wr_ready = 1'b1;
      drive_r0(16'hAAAA, 16'hBBBB, 1'b1);
      drive_r1(16'hCCCC, 16'hDDDD, 1'b1);
      step();
      step();
      rst_n = 1'b1;
      clear_lanes();
      checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", bus.wr_valid); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
      checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL reset_res_ready: got %b expected 1", bus.res_ready); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow_err); end
      checks++; if (bus.wr_bia !== 16'h0) begin errors++; $display("FAIL reset_wr_bia: got %h expected 0000", bus.wr_bia); end
   endtask

   task automatic test_dual_enqueue;
      do_reset();
      bus.wr_ready = 1'b1;
      drive_r0(16'h0010, 16'h0040, 1'b1);
      drive_r1(16'h0011, 16'h0080, 1'b0);
      step();
      clear_lanes();
      checks++;
      if ({bus.wr_valid, bus.wr_bia, bus.wr_bta, bus.wr_taken} !== {1'b1, 16'h0010, 16'h0040, 1'b1}) begin
         errors++;
         $display("FAIL dual_first: got v=%b %h/%h/%b expected v=1 0010/0040/1", bus.wr_valid, bus.wr_bia, bus.wr_bta, bus.wr_taken);
      end
      step();
      checks++;
      if ({bus.wr_valid, bus.wr_bia, bus.wr_bta, bus.wr_taken} !== {1'b1, 16'h0011, 16'h0080, 1'b0}) begin
         errors++;
         $display("FAIL dual_second: got v=%b %h/%h/%b expected v=1 0011/0080/0", bus.wr_valid, bus.wr_bia, bus.wr_bta, bus.wr_taken);
      end
      step();
      checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL dual_drained: got wr_valid=%b expected 0", bus.wr_valid); end
   endtask

   task automatic test_backpressure_overflow;
      logic [AW-1:0] exp_bia [4];
      exp_bia[0] = 16'h1000; exp_bia[1] = 16'h1001; exp_bia[2] = 16'h1002; exp_bia[3] = 16'h1003;
      do_reset();
      bus.wr_ready = 1'b0;
      drive_r0(16'h1000, 16'h2000, 1'b1);
      drive_r1(16'h1001, 16'h2001, 1'b0);
      step();
      drive_r0(16'h1002, 16'h2002, 1'b1);
      drive_r1(16'h1003, 16'h2003, 1'b0);
      step();
      clear_lanes();
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_count_full: got %0d expected 4", bus.count); end
      checks++; if (bus.res_ready !== 1'b0) begin errors++; $display("FAIL bp_res_ready_full: got %b expected 0", bus.res_ready); end
      checks++; if (bus.wr_bia !== 16'h1000 || bus.wr_bta !== 16'h2000) begin
         errors++; $display("FAIL bp_head_held: got %h/%h expected 1000/2000", bus.wr_bia, bus.wr_bta);
      end
      drive_r0(16'h1004, 16'h2004, 1'b1);
      drive_r1(16'h1005, 16'h2005, 1'b1);
      step();
      clear_lanes();
      checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL bp_overflow_set: got %b expected 1", bus.overflow_err); end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_count_after_drop: got %0d expected 4", bus.count); end
      bus.wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.wr_valid !== 1'b1 || bus.wr_bia !== exp_bia[i] || bus.wr_taken !== (i % 2 == 0)) begin
            errors++;
            $display("FAIL bp_drain_%0d: got v=%b bia=%h tk=%b expected v=1 bia=%h tk=%b",
                     i, bus.wr_valid, bus.wr_bia, bus.wr_taken, exp_bia[i], (i % 2 == 0));
         end
         step();
      end
      checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got wr_valid=%b expected 0", bus.wr_valid); end
      checks++; if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky: got %b expected 1", bus.overflow_err); end
   endtask

   task automatic test_wrap_around;
      logic [2*AW:0] exp_q [$];
      logic [2*AW:0] ent;
      int sent;
      int got;
      int op;
      sent = 0; got = 0; op = 0;
      do_reset();
      for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
         clear_lanes();
         bus.wr_ready = (cyc % 2 == 0);
         if (sent < 12 && bus.res_ready === 1'b1) begin
            if (op % 2 == 0) begin
               drive_r0(AW'(16'h0100 + sent), AW'(16'h0A00 + sent), (sent % 2 == 1));
               exp_q.push_back({AW'(16'h0100 + sent), AW'(16'h0A00 + sent), (sent % 2 == 1)});
               drive_r1(AW'(16'h0100 + sent + 1), AW'(16'h0A00 + sent + 1), ((sent + 1) % 2 == 1));
               exp_q.push_back({AW'(16'h0100 + sent + 1), AW'(16'h0A00 + sent + 1), ((sent + 1) % 2 == 1)});
               sent += 2;
            end else begin
               drive_r1(AW'(16'h0100 + sent), AW'(16'h0A00 + sent), (sent % 2 == 1));
               exp_q.push_back({AW'(16'h0100 + sent), AW'(16'h0A00 + sent), (sent % 2 == 1)});
               sent += 1;
            end
            op++;
         end
         checks++; if (bus.count > 3'd4) begin errors++; $display("FAIL wrap_count_bound: got %0d expected <=4", bus.count); end
         if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL wrap_extra_entry: got bia=%h expected none", bus.wr_bia);
            end else begin
               ent = exp_q.pop_front();
               if ({bus.wr_bia, bus.wr_bta, bus.wr_taken} !== ent) begin
                  errors++;
                  $display("FAIL wrap_entry_%0d: got %h/%h/%b expected %h/%h/%b", got,
                           bus.wr_bia, bus.wr_bta, bus.wr_taken, ent[2*AW:AW+1], ent[AW:1], ent[0]);
               end
            end
            got++;
         end
         step();
      end
      clear_lanes();
      checks++; if (got != 12) begin errors++; $display("FAIL wrap_delivered: got %0d expected 12", got); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", bus.count); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL wrap_overflow: got %b expected 0", bus.overflow_err); end
   endtask

   task automatic test_flush;
      do_reset();
      bus.wr_ready = 1'b0;
      drive_r0(16'h3000, 16'h4000, 1'b1);
      drive_r1(16'h3001, 16'h4001, 1'b0);
      step();
      clear_lanes();
      drive_r0(16'h3002, 16'h4002, 1'b1);
      step();
      clear_lanes();
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_setup_count: got %0d expected 3", bus.count); end
      bus.wr_ready = 1'b1;
      bus.flush    = 1'b1;
      drive_r0(16'h3003, 16'h4003, 1'b1);
      drive_r1(16'h3004, 16'h4004, 1'b1);
      checks++; if (bus.wr_valid !== 1'b1 || bus.wr_bia !== 16'h3000) begin
         errors++; $display("FAIL flush_head_delivered: got v=%b bia=%h expected v=1 bia=3000", bus.wr_valid, bus.wr_bia);
      end
      step();
      bus.flush = 1'b0;
      clear_lanes();
      bus.wr_ready = 1'b0;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", bus.count); end
      checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL flush_wr_valid: got %b expected 0", bus.wr_valid); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b expected 0", bus.overflow_err); end
      drive_r0(16'h3005, 16'h4005, 1'b0);
      step();
      clear_lanes();
      checks++; if (bus.wr_valid !== 1'b1 || bus.wr_bia !== 16'h3005 || bus.count !== 3'd1) begin
         errors++; $display("FAIL flush_reuse: got v=%b bia=%h cnt=%0d expected v=1 bia=3005 cnt=1", bus.wr_valid, bus.wr_bia, bus.count);
      end
   endtask

   task automatic test_reset_mid_op;
      do_reset();
      bus.wr_ready = 1'b0;
      drive_r0(16'h5000, 16'h6000, 1'b1);
      drive_r1(16'h5001, 16'h6001, 1'b1);
      step();
      clear_lanes();
      drive_r1(16'h5002, 16'h6002, 1'b0);
      step();
      clear_lanes();
      checks++; if (bus.res_ready !== 1'b0) begin errors++; $display("FAIL rmid_res_ready_at3: got %b expected 0", bus.res_ready); end
      drive_r0(16'h5003, 16'h6003, 1'b1);
      step();
      clear_lanes();
      checks++; if (bus.count !== 3'd3 || bus.overflow_err !== 1'b1) begin
         errors++; $display("FAIL rmid_setup: got cnt=%0d ovf=%b expected cnt=3 ovf=1", bus.count, bus.overflow_err);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", bus.count); end
      checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL rmid_wr_valid: got %b expected 0", bus.wr_valid); end
      checks++; if (bus.overflow_err !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b expected 0", bus.overflow_err); end
      drive_r0(16'h5010, 16'h6010, 1'b1);
      checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_bypass: got wr_valid=%b expected 0", bus.wr_valid); end
      step();
      clear_lanes();
      checks++; if ({bus.wr_valid, bus.wr_bia, bus.wr_bta, bus.wr_taken} !== {1'b1, 16'h5010, 16'h6010, 1'b1}) begin
         errors++; $display("FAIL rmid_single: got v=%b %h/%h/%b expected v=1 5010/6010/1", bus.wr_valid, bus.wr_bia, bus.wr_bta, bus.wr_taken);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clear_lanes();
      bus.flush    = 1'b0;
      bus.wr_ready = 1'b0;
      #2;
      test_reset();
      test_dual_enqueue();
      test_backpressure_overflow();
      test_wrap_around();
      test_flush();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
